// File: rtl/gfe_div_stream_if.sv
// Handshake bundle for gfe_div_stream: operand input side, result output side
// and the error event counter.
interface gfe_div_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_num;
    logic [1:0] in_den;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_q;
    logic       out_err;
    logic [7:0] err_count;

    modport slave (
        input  in_valid, in_num, in_den, out_ready,
        output in_ready, out_valid, out_q, out_err, err_count
    );

    modport master (
        output in_valid, in_num, in_den, out_ready,
        input  in_ready, out_valid, out_q, out_err, err_count
    );
endinterface

// File: rtl/gfe_div_stream.sv
// Streaming GF(3) divider: one compute register (s1) feeding a DEPTH-entry result FIFO.
// Define GFE_DIV_ERRCNT_EN to build the saturating error event counter on err_count.
module gfe_div_stream #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    gfe_div_stream_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       err;
        logic [1:0] q;
    } res_t;

    logic                s1_vld_q, s1_vld_d;
    res_t                s1_q, s1_d;
    res_t [DEPTH-1:0]    fifo_q, fifo_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    res_t                in_res;
    logic [3:0]          prod;
    logic                fifo_full, out_vld, pop, s1_move, in_rdy, accept;

    // In GF(3) every nonzero element is its own inverse, so division is a product mod 3.
    always_comb begin
        prod       = {2'b00, bus.in_num} * {2'b00, bus.in_den};
        in_res     = '0;
        if (bus.in_den == 2'd0 || bus.in_num == 2'd3 || bus.in_den == 2'd3) begin
            in_res.err = 1'b1;
        end else begin
            in_res.q = (prod >= 4'd3) ? 2'(prod - 4'd3) : prod[1:0];
        end
    end

    always_comb begin
        fifo_full = (cnt_q == CW'(DEPTH));
        out_vld   = (cnt_q != '0);
        pop       = out_vld && bus.out_ready;
        s1_move   = s1_vld_q && (!fifo_full || pop);
        in_rdy    = !rst && (!s1_vld_q || s1_move);
        accept    = bus.in_valid && in_rdy;

        s1_vld_d  = accept || (s1_vld_q && !s1_move);
        s1_d      = accept ? in_res : s1_q;

        fifo_d    = fifo_q;
        if (s1_move) fifo_d[wr_ptr_q] = s1_q;

        wr_ptr_d  = wr_ptr_q + AW'(s1_move);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        cnt_d     = cnt_q + CW'(s1_move) - CW'(pop);
    end

    // FIFO storage is left unreset; the output mux hides it whenever count is zero.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_q     = out_vld ? fifo_q[rd_ptr_q].q   : 2'd0;
    assign bus.out_err   = out_vld ? fifo_q[rd_ptr_q].err : 1'b0;

`ifdef GFE_DIV_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts at acceptance time, so errors still in flight are already included.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && in_res.err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 8'd0;
`endif
endmodule

// File: tb/tb_gfe_div_stream.sv
// Self-checking bench for gfe_div_stream: directed scenarios plus random traffic,
// scored against a queue-based reference of GF(3) division results.
module tb_gfe_div_stream;
    localparam int DEPTH = 4;
`ifdef GFE_DIV_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic clk, rst;
    gfe_div_stream_if ifc();

    gfe_div_stream #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pop  = 0;
    int n_acc  = 0;
    int n_err  = 0;
    logic [2:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Reference: q is the x in GF(3) with x*den == num; anything undefined is an error.
    function automatic logic [2:0] ref_div(input int n, input int d);
        if (n > 2 || d > 2 || d == 0) return 3'b100;
        for (int x = 0; x < 3; x++)
            if ((x * d) % 3 == n) return {1'b0, 2'(x)};
        return 3'b100;
    endfunction

    function automatic int exp_cnt();
        if (!ERRCNT) return 0;
        return (n_err > 255) ? 255 : n_err;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_err = 0;
        end else begin
            chk("err_count", 32'(ifc.err_count), 32'(exp_cnt()));
            if (!ifc.out_valid) chk("idle_zero", {29'd0, ifc.out_err, ifc.out_q}, 32'd0);
            if (ifc.out_valid && ifc.out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) chk("pop_underflow", 32'(exp_q.size()), 32'd1);
                else chk("pop_data", {29'd0, ifc.out_err, ifc.out_q}, {29'd0, exp_q.pop_front()});
            end
            if (ifc.in_valid && ifc.in_ready) begin
                logic [2:0] r;
                r = ref_div(int'(ifc.in_num), int'(ifc.in_den));
                exp_q.push_back(r);
                n_acc++;
                if (r[2]) n_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] n, input logic [1:0] d);
        bit got = 0;
        ifc.in_valid = 1'b1;
        ifc.in_num   = n;
        ifc.in_den   = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ifc.in_ready) begin got = 1; break; end
            @(posedge clk);
        end
        if (!got) chk("send_timeout", 32'(got), 32'd1);
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill(input int cycles, output int acc);
        acc = 0;
        for (int c = 0; c < cycles; c++) begin
            ifc.in_valid = 1'b1;
            ifc.in_num   = 2'($urandom_range(0, 3));
            ifc.in_den   = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (ifc.in_ready) acc++;
            tick();
        end
    endtask

    initial begin
        int acc, pops, p0;
        rst = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_num    = 2'd1;
        ifc.in_den    = 2'd1;
        ifc.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_q", 32'(ifc.out_q), 32'd0);
        chk("rst_out_err", 32'(ifc.out_err), 32'd0);
        chk("rst_err_count", 32'(ifc.err_count), 32'd0);
        chk("rst_nothing_taken", 32'(n_acc), 32'd0);

        // all 16 operand pairs
        ifc.out_ready = 1'b1;
        for (int n = 0; n < 4; n++)
            for (int d = 0; d < 4; d++) send(2'(n), 2'(d));
        drain();
        chk("pairs_accepted", 32'(n_acc), 32'd16);

        // minimum latency
        ifc.out_ready = 1'b1;
        send(2'd1, 2'd1);
        chk("lat_n", 32'(ifc.out_valid), 32'd0);
        tick();
        chk("lat_n1_valid", 32'(ifc.out_valid), 32'd1);
        chk("lat_n1_q", {30'd0, ifc.out_q}, 32'd1);
        tick();
        chk("lat_n2_valid", 32'(ifc.out_valid), 32'd0);

        // backpressure: FIFO plus s1
        ifc.out_ready = 1'b0;
        fill(10, acc);
        chk("bp_accepts", 32'(acc), 32'(DEPTH + 1));
        chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        p0 = n_pop;
        drain();
        chk("bp_pops", 32'(n_pop - p0), 32'(DEPTH + 1));

        // full with simultaneous push and pop
        ifc.out_ready = 1'b0;
        fill(10, acc);
        ifc.out_ready = 1'b1;
        acc = 0; pops = 0;
        for (int c = 0; c < 10; c++) begin
            ifc.in_valid = 1'b1;
            ifc.in_num   = 2'($urandom_range(0, 2));
            ifc.in_den   = 2'($urandom_range(1, 2));
            @(negedge clk);
            if (ifc.in_ready) acc++;
            if (ifc.out_valid) pops++;
            tick();
        end
        chk("full_accepts", 32'(acc), 32'd10);
        chk("full_pops", 32'(pops), 32'd10);
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            ifc.in_valid  = 1'($urandom_range(0, 1));
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            ifc.in_num    = 2'($urandom_range(0, 3));
            ifc.in_den    = 2'($urandom_range(0, 3));
            tick();
        end
        drain();

        // reset mid-stream
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_num    = 2'd2;
        ifc.in_den    = 2'd0;
        repeat (3) tick();
        ifc.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        ifc.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("mid_rst_err_count", 32'(ifc.err_count), 32'd0);
        ifc.out_ready = 1'b1;
        repeat (5) tick();
        chk("mid_rst_no_stale", 32'(ifc.out_valid), 32'd0);

        // error counter saturation
        ifc.out_ready = 1'b1;
        p0 = n_acc;
        ifc.in_valid = 1'b1;
        ifc.in_num   = 2'd1;
        ifc.in_den   = 2'd0;
        for (int c = 0; c < 400; c++) begin
            if (n_acc - p0 >= 300) break;
            tick();
        end
        ifc.in_valid = 1'b0;
        chk("cnt_accepts", 32'(n_acc - p0), 32'd300);
        tick();
        chk("cnt_sat", 32'(ifc.err_count), ERRCNT ? 32'd255 : 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gfe_div_stream.md
GFE_DIV_STREAM -- requirements
Module: gfe_div_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-006 SHALL have port in_num  input  2  GF(3) numerator, encoding 0,1,2; 3 is illegal.
REQ-007 SHALL have port in_den  input  2  GF(3) denominator, same encoding.
REQ-008 SHALL have port out_valid  output  1  result at FIFO head.
REQ-009 SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-010 SHALL have port out_q  output  2  quotient num * den^-1 mod 3.
REQ-011 SHALL have port out_err  output  1  quotient invalid (zero or illegal operand).
REQ-012 SHALL have port err_count  output  8  error event counter (see Configuration).

Function
REQ-013 SHALL accept an operand pair exactly on cycles with in_valid && in_ready.
REQ-014 SHALL compute q = (num * den) mod 3 (inverse of 1 is 1, of 2 is 2); err = 0.
REQ-015 SHALL, for den == 0, or num == 3, or den == 3, produce q = 0, err = 1.
REQ-016 SHALL register each accepted result in a one-entry compute stage (s1) on the accepting edge.
REQ-017 SHALL move s1 into the FIFO on the next edge when FIFO is not full or is popped that cycle; otherwise s1 holds.
REQ-018 SHALL assert in_ready when s1 is empty, or s1 moves into the FIFO this cycle (pass-through of occupancy).
REQ-019 SHALL give minimum latency 2 cycles: accepted at edge N, out_valid high after edge N+1 when FIFO empty.
REQ-020 SHALL pop the FIFO head on out_valid && out_ready; out_q/out_err hold stable while out_valid && !out_ready.
REQ-021 SHALL preserve acceptance order; no result dropped or duplicated.
REQ-022 SHALL support simultaneous push and pop when full: count unchanged, no loss.
REQ-023 SHALL wrap read/write pointers modulo DEPTH.
REQ-024 SHALL, with out_ready held 0, accept exactly DEPTH+1 pairs (FIFO plus s1), then deassert in_ready.
REQ-025 SHALL drive out_q = 0, out_err = 0 whenever out_valid = 0.

Reset
REQ-026 SHALL, while rst = 1, clear s1, FIFO pointers, count, and err_count on the next edge, regardless of inputs.
REQ-027 SHALL drive after reset: in_ready = 1, out_valid = 0, out_q = 0, out_err = 0, err_count = 0.
REQ-028 SHALL discard any data in flight when rst is asserted mid-stream; in_valid during rst is not accepted.

Configuration
REQ-029 SHALL support macro GFE_DIV_ERRCNT_EN.
REQ-030 SHALL, with GFE_DIV_ERRCNT_EN defined, increment err_count by 1 per accepted pair with err = 1, saturating at 255.
REQ-031 SHALL, without GFE_DIV_ERRCNT_EN, keep port err_count present, tied to 0, with no counter logic.

Verification
REQ-032 SHALL cover all 16 (num,den) pairs, out_ready = 1 -> e.g. (2,2)->q=1,err=0; (1,2)->q=2; (2,1)->q=2; (x,0)->q=0,err=1; (3,1)->err=1.
REQ-033 SHALL cover latency: single pair (1,1) accepted at edge N -> out_valid=1 after edge N+1, q=1; out_valid=0 after N+2.
REQ-034 SHALL cover backpressure: out_ready=0, DEPTH=4, continuous in_valid -> 5 accepts, in_ready=0; then out_ready=1 -> 5 results in order.
REQ-035 SHALL cover full with simultaneous push/pop: full FIFO, in_valid=1, out_ready=1 for 10 cycles -> 10 accepts, 10 pops, ordering intact.
REQ-036 SHALL cover reset mid-stream: 3 results queued, rst 1 cycle -> out_valid=0, in_ready=1, err_count=0; no stale output afterwards.
REQ-037 SHALL cover counter with macro: 300 pairs (1,0) -> err_count=255; without macro -> err_count=0 throughout.
